// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04-class ranging front end.
// Fires a trigger pulse on request, times the echo pulse, converts it to
// centimetres and reports it with a one-cycle strobe. Includes a timeout
// and an inter-measurement holdoff.
// Optional feature: define ULTRA_AVG_EN to report the mean of the last four
// non-timeout measurements instead of the raw single measurement.
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned DIST_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_ultra,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              ultrasonic_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned TRIG_W = $clog2(TRIG_CYCLES) + 1;
    localparam int unsigned SUB_W  = $clog2(CYCLES_PER_CM) + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES) + 1;

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_WAIT_ECHO,
        S_MEASURE,
        S_REPORT,
        S_HOLDOFF
    } state_t;

    state_t              r_state;
    logic                r_trig;
    logic [DIST_W-1:0]   r_distance;
    logic                r_valid;
    logic                r_timeout;
    logic [TRIG_W-1:0]   r_trig_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [SUB_W-1:0]    r_sub;
    logic [DIST_W-1:0]   r_cm;

    logic                r_echo_m;
    logic                r_echo_s;
    logic                r_echo_d;

    logic                w_echo_rise;
    logic                w_echo_fall;
    logic                w_tmo_hit;
    logic                w_meas_done;
    logic [DIST_W-1:0]   w_meas_dist;

    // Two-flop synchronizer for the asynchronous echo line plus a delay tap for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_echo_m <= 1'b0;
            r_echo_s <= 1'b0;
            r_echo_d <= 1'b0;
        end else begin
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            r_echo_d <= r_echo_s;
        end
    end

    assign w_echo_rise = r_echo_s & ~r_echo_d;
    assign w_echo_fall = ~r_echo_s & r_echo_d;
    assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
    // A falling edge takes priority over a coincident timeout
    assign w_meas_done = (r_state == S_MEASURE) && w_echo_fall;

`ifdef ULTRA_AVG_EN
    logic [DIST_W-1:0] r_hist [0:2];
    logic [DIST_W+1:0] w_avg_sum;

    // The newest measurement plus the three previous ones form the averaging window
    assign w_avg_sum = (DIST_W+2)'(r_cm) + (DIST_W+2)'(r_hist[0])
                     + (DIST_W+2)'(r_hist[1]) + (DIST_W+2)'(r_hist[2]);
    assign w_meas_dist = w_avg_sum[DIST_W+1:2];

    // History shifts only on non-timeout reports
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_meas_done) begin
            r_hist[0] <= r_cm;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
        end
    end
`else
    assign w_meas_dist = r_cm;
`endif

    // Measurement sequencer: trigger, echo wait, echo timing, report, holdoff
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_trig     <= 1'b0;
            r_distance <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_trig_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_hold_cnt <= '0;
            r_sub      <= '0;
            r_cm       <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_ultra) begin
                        r_state    <= S_TRIGGER;
                        r_trig     <= 1'b1;
                        r_trig_cnt <= '0;
                    end
                end
                S_TRIGGER: begin
                    if (r_trig_cnt == TRIG_LAST) begin
                        r_trig    <= 1'b0;
                        r_state   <= S_WAIT_ECHO;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + 1'b1;
                    end
                end
                S_WAIT_ECHO: begin
                    if (w_tmo_hit) begin
                        r_distance <= DIST_MAX;
                        r_timeout  <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= S_REPORT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (w_echo_rise) begin
                            r_state <= S_MEASURE;
                            r_cm    <= '0;
                            r_sub   <= '0;
                        end
                    end
                end
                S_MEASURE: begin
                    if (w_echo_fall) begin
                        r_distance <= w_meas_dist;
                        r_timeout  <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= S_REPORT;
                    end else if (w_tmo_hit) begin
                        r_distance <= DIST_MAX;
                        r_timeout  <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= S_REPORT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_sub == SUB_LAST) begin
                            r_sub <= '0;
                            if (r_cm != DIST_MAX) begin
                                r_cm <= r_cm + 1'b1;
                            end
                        end else begin
                            r_sub <= r_sub + 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    r_state    <= S_HOLDOFF;
                    r_hold_cnt <= '0;
                end
                S_HOLDOFF: begin
                    // Counter parks at its last value while the echo line is still high
                    if (r_hold_cnt == HOLD_LAST) begin
                        if (!r_echo_s) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trig  <= 1'b0;
                end
            endcase
        end
    end

    assign trig             = r_trig;
    assign distance         = r_distance;
    assign ultrasonic_valid = r_valid;
    assign timeout          = r_timeout;
    assign busy             = (r_state != S_IDLE);

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Upstream stage of the communication controller. It produces the sensor reading that the controller waits on before it starts a UART transaction. On `start_ultra` it fires a trigger pulse at an HC-SR04-class ultrasonic sensor, measures the width of the returned echo pulse, and converts it to centimetres. It then presents `distance` with a one-cycle `ultrasonic_valid` strobe, and enforces a timeout and an inter-measurement holdoff.

Parameters:
- TRIG_CYCLES, 500: trigger pulse width in clk cycles (10 us at 50 MHz).
- CYCLES_PER_CM, 2900: echo-high clk cycles per centimetre (58 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000: maximum cycles from entering WAIT_ECHO to a report (30 ms).
- HOLDOFF_CYCLES, 3000000: minimum idle gap after a report before the next trigger (60 ms).
- DIST_W, 8: width of the distance output in cm.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start_ultra  input  1  level request from the controller; sampled only in IDLE.
- echo  input  1  asynchronous sensor echo line.
- trig  output  1  registered sensor trigger.
- distance  output  DIST_W  last measured distance in cm; held between reports.
- ultrasonic_valid  output  1  one-cycle strobe; `distance` and `timeout` are valid in that cycle.
- timeout  output  1  set when the last report ended by timeout; held with `distance`.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clock/reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: trig=0, distance=0, ultrasonic_valid=0, timeout=0, busy=0, state=IDLE. Synchronizer flops and all counters are also 0.
- Reset mid-operation: it takes effect at the next edge from any state, and trig drops that edge. No valid strobe is emitted for the aborted measurement.
- Echo input: passes through a 2-FF synchronizer to give echo_s. A rising edge is echo_s=1 while the previous echo_s=0. A falling edge is the reverse.
- IDLE: if start_ultra=1 at edge N, go to TRIGGER. trig is high in cycles N+1 through N+TRIG_CYCLES inclusive.
- TRIGGER: after TRIG_CYCLES cycles, drop trig, enter WAIT_ECHO, and clear the timeout counter.
- WAIT_ECHO:
  - On an echo_s rising edge, go to MEASURE with cm=0 and sub=0.
  - An echo already high on entry is ignored until a fresh rising edge.
- MEASURE: each cycle, sub increments. When sub reaches CYCLES_PER_CM-1, it wraps to 0 and cm increments, saturating at 2^DIST_W-1. On an echo_s falling edge, go to REPORT with timeout_next=0.
- Timeout counter:
  - Runs through WAIT_ECHO and MEASURE.
  - If it reaches TIMEOUT_CYCLES, go to REPORT with distance=2^DIST_W-1 and timeout_next=1.
  - A falling edge and the timeout in the same cycle: the falling edge wins, so timeout=0 and the measured cm is used.
- REPORT:
  - On entry, distance and timeout are loaded.
  - ultrasonic_valid=1 for exactly this one cycle; the state then goes to HOLDOFF.
  - Never two consecutive strobes.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES, then goes to IDLE only if echo_s=0. Otherwise it stays until the echo is released.
  - start_ultra is ignored here, so held requests are serviced on return to IDLE.
- start_ultra dropping mid-measurement: ignored; the measurement completes and strobes.
- Controller compatibility: a start_ultra held high through the strobe cycle causes no double trigger, because the state is in HOLDOFF the following cycle.
- Counter widths: each counter is $clog2 of its maximum parameter plus 1. No arithmetic wrap other than sub.

Optional Feature:
- Macro: ULTRA_AVG_EN.
- When defined:
  - A 4-entry history of non-timeout results is kept (reset to 0, shifted on each non-timeout report).
  - On a non-timeout report, distance = (sum of 4 entries) >> 2, using a DIST_W+2-bit sum.
  - Timeout reports output 2^DIST_W-1 and timeout=1, leaving the history unchanged.
- When undefined: distance is the raw single measurement; no history logic is synthesized.

Test Plan:
All scenarios use TRIG_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=200, HOLDOFF_CYCLES=20, DIST_W=8 unless stated.
1. start_ultra held high; echo high for 57 cycles, starting 10 cycles after trig falls -> trig high exactly 4 cycles; one ultrasonic_valid; distance=5; timeout=0; busy high until 20+ cycles after the strobe; start_ultra still high re-triggers only after HOLDOFF.
2. start_ultra pulse; echo never rises -> strobe 200 cycles after WAIT_ECHO entry; distance=255; timeout=1.
3. DIST_W=4, TIMEOUT_CYCLES=1000; echo high for 170 cycles -> distance=15 (saturated, not 17 or 1); timeout=0.
4. echo stuck high from before trigger -> timeout report (distance=255, timeout=1); after the strobe, busy stays 1 beyond 20 holdoff cycles until echo is released, then returns to IDLE.
5. reset asserted for one cycle mid-MEASURE -> next cycle trig=0, ultrasonic_valid=0, distance=0, busy=0; no strobe afterwards without a new start_ultra.
6. ULTRA_AVG_EN defined; four measurements of 4, 8, 12, 16 cm -> strobed distances 1, 3, 6, 10; a following timeout gives 255, and the next 20 cm measurement gives 14.
